// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: FSM encoding, access size
// codes and the alignment rule applied when a request is accepted.
package mau_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } mau_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // 1 when the access cannot be performed: illegal size or misaligned lane.
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] lane);
    logic fault;
    case (size)
      SZ_BYTE: fault = 1'b0;
      SZ_HALF: fault = lane[0];
      SZ_WORD: fault = |lane;
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/mau_align.sv
// Combinational lane logic: extracts and extends load data from a memory
// word, and merges right-aligned store data into a word for read-modify-write.
module mau_align
  import mau_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_byte_sign;
  logic        w_half_sign;

  // Load path: pick the addressed lane, then zero- or sign-extend it.
  always_comb begin
    w_byte      = i_rword[{i_lane, 3'b000} +: 8];
    w_half      = i_lane[1] ? i_rword[31:16] : i_rword[15:0];
    w_byte_sign = ~i_unsigned & w_byte[7];
    w_half_sign = ~i_unsigned & w_half[15];
    case (i_size)
      SZ_BYTE: o_load_data = {{24{w_byte_sign}}, w_byte};
      SZ_HALF: o_load_data = {{16{w_half_sign}}, w_half};
      default: o_load_data = i_rword;
    endcase
  end

  // Store path: replace only the addressed lane(s) of the word just read.
  always_comb begin
    o_merge_word = i_rword;
    case (i_size)
      SZ_BYTE: o_merge_word[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      SZ_HALF: begin
        if (i_lane[1]) o_merge_word[31:16] = i_wdata[15:0];
        else           o_merge_word[15:0]  = i_wdata[15:0];
      end
      SZ_WORD: o_merge_word = i_wdata;
      default: o_merge_word = i_rword;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and a word-wide data memory
// without byte enables. Sub-word stores are done as read-modify-write.
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only while idle, and the result is a
// single-cycle rsp_valid pulse whose data/err stay registered afterwards.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output mau_state_e           dbg_state
);

  mau_state_e           r_state;
  mau_state_e           w_next;
  logic                 w_accept;
  logic                 w_fault;
  logic                 w_word_store;
  logic                 r_we;
  logic [1:0]           r_size;
  logic                 r_unsigned;
  logic [1:0]           r_lane;
  logic [31:0]          r_wdata;
  logic [ADDR_BITS-1:0] r_mem_addr;
  logic [31:0]          r_mem_wdata;
  logic [31:0]          r_rsp_rdata;
  logic                 r_rsp_err;
  logic [31:0]          w_load_data;
  logic [31:0]          w_merge_word;

  assign w_accept     = req_valid & (r_state == ST_IDLE);
  assign w_fault      = access_fault(req_size, req_addr[1:0]);
  assign w_word_store = req_we & (req_size == SZ_WORD);

  // State register; reset abandons whatever transaction is in flight.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: faults skip memory, word stores skip the read.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_fault)           w_next = ST_RESP;
          else if (w_word_store) w_next = ST_WR;
          else                   w_next = ST_RD;
        end
      end
      ST_RD:   w_next = ST_CAP;
      ST_CAP:  w_next = r_we ? ST_WR : ST_RESP;
      ST_WR:   w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  mau_align u_align (
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_lane       (r_lane),
    .i_rword      (mem_rdata),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_word (w_merge_word)
  );

  // Request capture, write word build-up and response registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_we        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_unsigned  <= 1'b0;
      r_lane      <= 2'b00;
      r_wdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata;
            r_mem_addr <= req_addr[ADDR_BITS+1:2];
            if (w_fault) begin
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b1;
            end else if (w_word_store) begin
              r_mem_wdata <= req_wdata;
            end
          end
        end
        ST_CAP: begin
          // mem_rdata is valid here, one cycle after the read strobe.
          if (r_we) begin
            r_mem_wdata <= w_merge_word;
          end else begin
            r_rsp_rdata <= w_load_data;
            r_rsp_err   <= 1'b0;
          end
        end
        ST_WR: begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign mem_re    = (r_state == ST_RD);
  assign mem_we    = (r_state == ST_WR);
  assign rsp_valid = (r_state == ST_RESP);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random requests against
// a word-array reference model of the memory and the access rules.
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int AB    = 10;
  localparam int WORDS = 1 << AB;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [AB-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  mau_state_e    dbg_state;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.ADDR_BITS(AB)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 Clock = ~Clock;

  // Attached memory: synchronous read, data one cycle after mem_re.
  always @(posedge Clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: outcome of one request from the access rules alone.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata, output int lat,
                       output int n_re, output int n_we, output logic [31:0] new_word);
    int unsigned idx;
    int unsigned sh;
    logic [31:0] word;
    logic [31:0] mask;
    idx   = int'(addr >> 2) % WORDS;
    sh    = int'(addr % 4) * 8;
    word  = ref_mem[idx];
    err   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && (addr % 4) != 0);
    rdata = 32'h0;
    new_word = word;
    n_re = 0; n_we = 0; lat = 1;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      n_re = 1; lat = 3;
      if (size == 2'd0) begin
        rdata = (word >> sh) & 32'hFF;
        if (!uns && rdata[7]) rdata = rdata | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        rdata = (word >> sh) & 32'hFFFF;
        if (!uns && rdata[15]) rdata = rdata | 32'hFFFF_0000;
      end else begin
        rdata = word;
      end
    end else begin
      n_we = 1;
      if (size == 2'd2) begin
        lat = 2; new_word = wdata;
      end else begin
        n_re = 1; lat = 4;
        mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        new_word = (word & ~mask) | ((wdata << sh) & mask);
      end
      ref_mem[idx] = new_word;
    end
  endtask

  // Driver + monitor for one request; caller is at a falling edge.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit hold, input bit expect_b2b);
    logic err;
    logic [31:0] rdata;
    logic [31:0] new_word;
    logic [31:0] got_rdata;
    logic [31:0] exp_rdata;
    logic got_err;
    int lat, n_re, n_we, waits, re_seen, we_seen, re_cyc, we_cyc, rsp_cyc;
    bit rdy, accepted, got_rsp;
    logic [AB-1:0] idx;
    idx = addr[AB+1:2];
    model(we, size, uns, addr, wdata, err, rdata, lat, n_re, n_we, new_word);
    exp_q.push_back(rdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    waits = 0; accepted = 0;
    while (!accepted && waits < 10) begin
      rdy = req_ready;
      @(posedge Clock);
      if (rdy) accepted = 1;
      else begin
        waits++;
        @(negedge Clock);
      end
    end
    if (!accepted) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      void'(exp_q.pop_front());
      @(negedge Clock);
      return;
    end
    if (expect_b2b) check_eq("b2b_accept_wait", waits, 32'd1);
    // Scramble the request fields: the unit must work from its captured copy.
    #1;
    if (!hold) req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    re_seen = 0; we_seen = 0; re_cyc = 0; we_cyc = 0; rsp_cyc = 0; got_rsp = 0;
    got_rdata = '0; got_err = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      if (mem_re && mem_we) check_eq("re_we_overlap", 32'd1, 32'd0);
      if (mem_re) begin
        re_seen++; re_cyc = k;
        check_eq("re_addr", 32'(mem_addr), 32'(idx));
      end
      if (mem_we) begin
        we_seen++; we_cyc = k;
        check_eq("we_addr", 32'(mem_addr), 32'(idx));
        check_eq("we_data", mem_wdata, new_word);
      end
      if (rsp_valid) begin
        got_rsp = 1; rsp_cyc = k; got_rdata = rsp_rdata; got_err = rsp_err;
        break;
      end
    end
    exp_rdata = exp_q.pop_front();
    if (!got_rsp) begin
      check_eq("rsp_timeout", 32'd0, 32'd1);
    end else begin
      check_eq("rsp_latency", rsp_cyc, lat);
      check_eq("rsp_err", 32'(got_err), 32'(err));
      check_eq("rsp_rdata", got_rdata, exp_rdata);
    end
    check_eq("re_count", re_seen, n_re);
    check_eq("we_count", we_seen, n_we);
    if (n_re == 1) check_eq("re_cycle", re_cyc, 32'd1);
    if (n_we == 1) check_eq("we_cycle", we_cyc, lat - 1);
    if (!hold) begin
      @(negedge Clock);
      check_eq("ready_after_rsp", 32'(req_ready), 32'd1);
      check_eq("rsp_single_pulse", 32'(rsp_valid), 32'd0);
      check_eq("rsp_rdata_hold", rsp_rdata, exp_rdata);
      check_eq("rsp_err_hold", 32'(rsp_err), 32'(err));
    end
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end

    // Reset
    repeat (3) @(negedge Clock);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_mem_re", 32'(mem_re), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clock);
    check_eq("post_rst_ready", 32'(req_ready), 32'd1);

    // Directed scenarios
    mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
    run_txn(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0, 0, 0);
    mem[4] = 32'h80FF_1234; ref_mem[4] = 32'h80FF_1234;
    run_txn(1'b0, SZ_BYTE, 1'b0, 32'h0000_0013, 32'h0, 0, 0);
    run_txn(1'b0, SZ_BYTE, 1'b1, 32'h0000_0013, 32'h0, 0, 0);
    run_txn(1'b0, SZ_HALF, 1'b0, 32'h0000_0012, 32'h0, 0, 0);
    mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
    run_txn(1'b1, SZ_BYTE, 1'b0, 32'h0000_0011, 32'hFFFF_FFAB, 0, 0);
    run_txn(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0, 0, 0);
    run_txn(1'b1, SZ_HALF, 1'b0, 32'h0000_0012, 32'h1234_5678, 0, 0);
    run_txn(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0, 0, 0);
    run_txn(1'b0, SZ_WORD, 1'b0, 32'h0000_0002, 32'h0, 0, 0);
    run_txn(1'b1, SZ_HALF, 1'b0, 32'h0000_0021, 32'h5555_5555, 0, 0);
    run_txn(1'b0, SZ_ILL,  1'b0, 32'h0000_0020, 32'h0, 0, 0);

    // Reset while a half store sits in its capture state
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_HALF; req_unsigned = 1'b0;
    req_addr = 32'h0000_0022; req_wdata = 32'h0000_CAFE;
    @(posedge Clock);
    #1 req_valid = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check_eq("abort_in_cap", 32'(dbg_state), 32'(ST_CAP));
    Reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      check_eq("abort_no_we", 32'(mem_we), 32'd0);
      check_eq("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      check_eq("abort_ready", 32'(req_ready), 32'd1);
      check_eq("abort_no_we_after", 32'(mem_we), 32'd0);
      check_eq("abort_no_rsp_after", 32'(rsp_valid), 32'd0);
    end
    run_txn(1'b1, SZ_WORD, 1'b0, 32'h0000_0024, 32'h0BAD_F00D, 0, 0);
    run_txn(1'b0, SZ_WORD, 1'b0, 32'h0000_0020, 32'h0, 0, 0);
    run_txn(1'b0, SZ_WORD, 1'b0, 32'h0000_0024, 32'h0, 0, 0);

    // Back-to-back with req_valid held, including aliased addresses
    run_txn(1'b1, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0102_0304, 1, 0);
    run_txn(1'b0, SZ_WORD, 1'b0, 32'h0000_1010, 32'h0, 1, 1);
    run_txn(1'b1, SZ_BYTE, 1'b0, 32'h8000_1013, 32'h0000_00EE, 1, 1);
    run_txn(1'b0, SZ_HALF, 1'b1, 32'h0000_0012, 32'h0, 1, 1);
    run_txn(1'b0, SZ_WORD, 1'b0, 32'h0000_0011, 32'h0, 1, 1);
    run_txn(1'b0, SZ_BYTE, 1'b0, 32'h0000_1013, 32'h0, 0, 1);

    // Random traffic, biased toward a few words so stores are read back
    for (int i = 0; i < 80; i++) begin
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & 32'hF000_003F;
      run_txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
              0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_BITS, default 10: word-address width of the attached data memory.
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  unit idle and accepting; handshake = req_valid & req_ready at rising edge.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend; ignored for stores.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 mem_addr  output  ADDR_BITS  word address = captured addr[ADDR_BITS+1:2]; higher bits ignored (wrap).
REQ-012 mem_re  output  1  read strobe; mem_rdata valid in the following cycle.
REQ-013 mem_we  output  1  full-word write strobe; memory has no byte enables.
REQ-014 mem_wdata  output  32  write word.
REQ-015 mem_rdata  input  32  read word.
REQ-016 rsp_valid  output  1  one-cycle completion pulse.
REQ-017 rsp_rdata  output  32  formatted load data; 0 for stores and errors.
REQ-018 rsp_err  output  1  valid with rsp_valid; 1 = misaligned or illegal size.

Function
REQ-019 FSM states: IDLE, RD, CAP, WR, RESP; req_ready = 1 only in IDLE.
REQ-020 On handshake all req_* fields are captured; inputs may change afterwards without effect.
REQ-021 Error check at accept: size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> IDLE->RESP with rsp_err=1, no mem_re/mem_we ever asserted.
REQ-022 Word store: IDLE->WR (mem_we=1, mem_wdata=req_wdata)->RESP; accept edge N, mem_we in cycle N+1, rsp_valid in cycle N+2.
REQ-023 Load: IDLE->RD (mem_re=1)->CAP (mem_rdata registered)->RESP; rsp_valid in cycle N+3.
REQ-024 Byte/half store (read-modify-write): IDLE->RD->CAP->WR->RESP; mem_wdata = captured word with only the lane(s) selected by addr[1:0] replaced; rsp_valid in cycle N+4.
REQ-025 Load lane select: byte lane addr[1:0], half lane addr[1]; extended per req_unsigned; word passes unchanged.
REQ-026 mem_addr holds the captured word address for the entire transaction, including RD and WR.
REQ-027 mem_re and mem_we never both 1; each is 1 for exactly one cycle per transaction.
REQ-028 RESP always returns to IDLE; req_ready rises the cycle after rsp_valid (no accept during RESP).
REQ-029 rsp_rdata and rsp_err are registered and remain stable until the next RESP.

Reset
REQ-030 Reset_n low asynchronously forces IDLE, req_ready=1 after release, mem_re=mem_we=rsp_valid=rsp_err=0, rsp_rdata=0, mem_wdata=0, mem_addr=0.
REQ-031 Reset during any state aborts the transaction: no response is issued and a pending WR is dropped.

Structure
REQ-032 A shared package mau_pkg holds the state encoding and the size codes (SZ_BYTE, SZ_HALF, SZ_WORD).
REQ-033 A combinational sub-module mau_align performs load extraction/extension and store lane merge; the FSM stays in mem_access_unit.

Verification
REQ-034 Load word addr 0x0000_0010, memory word 4 = 0xDEAD_BEEF -> mem_re in N+1 with mem_addr=4, rsp_valid in N+3, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
REQ-035 Signed byte load addr 0x13, word 4 = 0x80FF_1234 -> rsp_rdata=0xFFFF_FF80; repeat with req_unsigned=1 -> 0x0000_0080.
REQ-036 Byte store 0xAB to addr 0x11, word 4 = 0x1122_3344 -> exactly one mem_re, then mem_we in N+3 with mem_wdata=0x1122_AB44, rsp_valid in N+4.
REQ-037 Word load addr 0x02 -> rsp_valid in N+1 with rsp_err=1, rsp_rdata=0, mem_re and mem_we never asserted.
REQ-038 Start half store, assert Reset_n low in CAP -> mem_we never asserted, no rsp_valid, req_ready=1 after release; following word store completes normally.
REQ-039 Back-to-back requests with req_valid held high -> second accepted the cycle after first rsp_valid; addr bit ADDR_BITS+2 set aliases to the same mem_addr.
